// File: rtl/corelet_pkg.sv
// corelet_pkg: shared FSM state, command opcodes and array instruction encodings for corelet_seq.
package corelet_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StExec,
      StFlush,
      StDrain
   } state_e;

   localparam logic [1:0] OpLoad  = 2'd0;
   localparam logic [1:0] OpExec  = 2'd1;
   localparam logic [1:0] OpDrain = 2'd2;
   localparam logic [1:0] OpBad   = 2'd3;

   localparam logic [1:0] InstNop  = 2'b00;
   localparam logic [1:0] InstLoad = 2'b01;
   localparam logic [1:0] InstExec = 2'b10;

   localparam int unsigned FifoDepth = 8;
   localparam int unsigned PtrW      = $clog2(FifoDepth);

endpackage

// File: rtl/corelet_seq_ctrl.sv
// corelet_seq_ctrl: command FSM, read/pop counters, flush timer and done/err pulses.
module corelet_seq_ctrl
   import corelet_pkg::*;
#(
   parameter int unsigned row   = 8,
   parameter int unsigned col   = 8,
   parameter int unsigned LEN_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cmd_valid_i,
   input  logic [1:0]       cmd_op_i,
   input  logic [LEN_W-1:0] cmd_len_i,
   input  logic             cmd_acc_i,
   input  logic             mode_i,
   input  logic             l0_empty_i,
   input  logic             if_empty_i,
   input  logic             of_valid_i,
   input  logic             out_ready_i,
   input  logic             wr_err_i,
   output logic             cmd_ready_o,
   output logic             done_o,
   output logic             err_o,
   output logic             out_valid_o,
   output logic             acc_o,
   output logic             mode_o,
   output state_e           state_o,
   output logic [1:0]       inst_w_o,
   output logic             l0_rd_o,
   output logic             if_rd_o,
   output logic             of_pop_o
);
   localparam int unsigned    FlW    = $clog2(row + col + 1);
   localparam logic [FlW-1:0] FlLast = FlW'(row + col - 1);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
   logic [FlW-1:0]   fl_q, fl_d;
   logic             acc_q, acc_d, mode_q, mode_d;
   logic             done_q, done_d, err_q, err_d;
   logic             os_exec;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      fl_d        = fl_q;
      acc_d       = acc_q;
      mode_d      = mode_q;
      done_d      = 1'b0;
      err_d       = wr_err_i;
      os_exec     = 1'b0;
      inst_w_o    = InstNop;
      l0_rd_o     = 1'b0;
      if_rd_o     = 1'b0;
      of_pop_o    = 1'b0;
      out_valid_o = 1'b0;
      case (state_q)
         StIdle: begin
            if (cmd_valid_i) begin
               len_d  = cmd_len_i;
               acc_d  = cmd_acc_i;
               mode_d = mode_i;
               cnt_d  = '0;
               if (cmd_op_i == OpBad) begin
                  err_d = 1'b1;
               end else if (cmd_len_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  case (cmd_op_i)
                     OpLoad:  state_d = StLoad;
                     OpExec:  state_d = StExec;
                     default: state_d = StDrain;
                  endcase
               end
            end
         end
         StLoad, StExec: begin
            // Output-stationary execution consumes L0 and IFIFO in lockstep.
            os_exec = (state_q == StExec) && mode_q;
            if (!l0_empty_i && !(os_exec && if_empty_i)) begin
               l0_rd_o  = 1'b1;
               if_rd_o  = os_exec;
               inst_w_o = (state_q == StLoad) ? InstLoad : InstExec;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_d == len_q) begin
                  state_d = StFlush;
                  fl_d    = '0;
               end
            end
         end
         StFlush: begin
            if (fl_q == FlLast) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else begin
               fl_d = fl_q + 1'b1;
            end
         end
         StDrain: begin
            out_valid_o = of_valid_i;
            if (of_valid_i && out_ready_i) begin
               of_pop_o = 1'b1;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_d == len_q) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         len_q   <= '0;
         cnt_q   <= '0;
         fl_q    <= '0;
         acc_q   <= 1'b0;
         mode_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         fl_q    <= fl_d;
         acc_q   <= acc_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign cmd_ready_o = (state_q == StIdle);
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign acc_o       = acc_q;
   assign mode_o      = mode_q;
   assign state_o     = state_q;

endmodule

// File: rtl/corelet_seq.sv
// corelet_seq: command sequencer around L0/IFIFO, MAC array, OFIFO and SFP accumulate stage.
// Define CORELET_SEQ_OS_EN to build the output-stationary IFIFO path; otherwise mode is ignored.
module corelet_seq
   import corelet_pkg::*;
#(
   parameter int unsigned bw      = 4,
   parameter int unsigned psum_bw = 16,
   parameter int unsigned row     = 8,
   parameter int unsigned col     = 8,
   parameter int unsigned LEN_W   = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mode,
   input  logic [bw*row-1:0]      act_in,
   input  logic                   act_wr,
   input  logic [bw*row-1:0]      w_in,
   input  logic                   w_wr,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [LEN_W-1:0]       cmd_len,
   input  logic                   cmd_acc,
   input  logic [psum_bw*col-1:0] sfp_in,
   output logic [psum_bw*col-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic                   in_full
);
   localparam int unsigned     CntW    = PtrW + 1;
   localparam logic [CntW-1:0] CntFull = CntW'(FifoDepth);

   state_e                   state;
   logic [1:0]               inst_w;
   logic                     l0_rd, if_rd, of_pop, acc_q, mode_q, mode_eff;
   logic                     if_empty, if_full, wr_err;
   logic [psum_bw*col-1:0]   in_n;

   // L0 activation FIFO
   logic [bw*row-1:0] l0_mem [FifoDepth];
   logic [bw*row-1:0] l0_rdata;
   logic [PtrW-1:0]   l0_wp_q, l0_rp_q;
   logic [CntW-1:0]   l0_cnt_q;
   logic              l0_full, l0_empty, l0_push;

   assign l0_full  = (l0_cnt_q == CntFull);
   assign l0_empty = (l0_cnt_q == '0);
   assign l0_push  = act_wr && !l0_full;
   assign l0_rdata = l0_mem[l0_rp_q];

   always_ff @(posedge clk) begin
      if (l0_push) l0_mem[l0_wp_q] <= act_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         l0_wp_q  <= '0;
         l0_rp_q  <= '0;
         l0_cnt_q <= '0;
      end else begin
         if (l0_push) l0_wp_q <= l0_wp_q + 1'b1;
         if (l0_rd)   l0_rp_q <= l0_rp_q + 1'b1;
         l0_cnt_q <= l0_cnt_q + CntW'(l0_push) - CntW'(l0_rd);
      end
   end

`ifdef CORELET_SEQ_OS_EN
   logic [bw*row-1:0] if_mem [FifoDepth];
   logic [bw*row-1:0] if_rdata;
   logic [PtrW-1:0]   if_wp_q, if_rp_q;
   logic [CntW-1:0]   if_cnt_q;
   logic              if_push;

   assign if_full  = (if_cnt_q == CntFull);
   assign if_empty = (if_cnt_q == '0);
   assign if_push  = w_wr && !if_full;
   assign if_rdata = if_mem[if_rp_q];
   assign mode_eff = mode;
   assign wr_err   = (act_wr && l0_full) || (w_wr && if_full);

   always_ff @(posedge clk) begin
      if (if_push) if_mem[if_wp_q] <= w_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         if_wp_q  <= '0;
         if_rp_q  <= '0;
         if_cnt_q <= '0;
      end else begin
         if (if_push) if_wp_q <= if_wp_q + 1'b1;
         if (if_rd)   if_rp_q <= if_rp_q + 1'b1;
         if_cnt_q <= if_cnt_q + CntW'(if_push) - CntW'(if_rd);
      end
   end

   always_comb begin
      in_n = '0;
      if (if_rd) begin
         for (int c = 0; c < int'(col); c++) begin
            // Columns beyond the row count reuse IFIFO lanes modulo row.
            in_n[c*psum_bw +: psum_bw] = psum_bw'(signed'(if_rdata[(c % int'(row))*bw +: bw]));
         end
      end
   end
`else
   logic unused_os;
   assign unused_os = ^{mode, w_in, if_rd};
   assign mode_eff  = 1'b0;
   assign if_empty  = 1'b1;
   assign if_full   = 1'b0;
   assign wr_err    = (act_wr && l0_full) || w_wr;
   assign in_n      = '0;
`endif

   // MAC array: LOAD latches a weight row, EXEC yields one result row a cycle later.
   logic [bw*row-1:0]         w_q;
   logic [psum_bw*col-1:0]    res_q, res_d;
   logic                      res_vld_q;
   logic signed [psum_bw-1:0] dot;

   always_comb begin
      dot = '0;
      for (int r = 0; r < int'(row); r++) begin
         dot = dot + psum_bw'(signed'(l0_rdata[r*bw +: bw])) *
                     psum_bw'(signed'(w_q[r*bw +: bw]));
      end
      res_d = '0;
      for (int c = 0; c < int'(col); c++) begin
         res_d[c*psum_bw +: psum_bw] = dot + in_n[c*psum_bw +: psum_bw];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_q       <= '0;
         res_q     <= '0;
         res_vld_q <= 1'b0;
      end else begin
         if (inst_w == InstLoad) w_q <= l0_rdata;
         if (inst_w == InstExec) res_q <= res_d;
         res_vld_q <= (inst_w == InstExec);
      end
   end

   // OFIFO; a result arriving while full is dropped.
   logic [psum_bw*col-1:0] of_mem [FifoDepth];
   logic [psum_bw*col-1:0] of_rdata;
   logic [PtrW-1:0]        of_wp_q, of_rp_q;
   logic [CntW-1:0]        of_cnt_q;
   logic                   of_push, of_valid;

   assign of_valid = (of_cnt_q != '0);
   assign of_push  = res_vld_q && (of_cnt_q != CntFull);
   assign of_rdata = of_mem[of_rp_q];

   always_ff @(posedge clk) begin
      if (of_push) of_mem[of_wp_q] <= res_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         of_wp_q  <= '0;
         of_rp_q  <= '0;
         of_cnt_q <= '0;
      end else begin
         if (of_push) of_wp_q <= of_wp_q + 1'b1;
         if (of_pop)  of_rp_q <= of_rp_q + 1'b1;
         of_cnt_q <= of_cnt_q + CntW'(of_push) - CntW'(of_pop);
      end
   end

   // SFP: per-column accumulate of sfp_in onto the OFIFO head.
   always_comb begin
      out_data = '0;
      if (out_valid) begin
         for (int c = 0; c < int'(col); c++) begin
            out_data[c*psum_bw +: psum_bw] = of_rdata[c*psum_bw +: psum_bw] +
               ((acc_q && !mode_q) ? sfp_in[c*psum_bw +: psum_bw] : '0);
         end
      end
   end

   assign busy    = (state != StIdle);
   assign in_full = l0_full || if_full;

   corelet_seq_ctrl #(
      .row   (row),
      .col   (col),
      .LEN_W (LEN_W)
   ) u_ctrl (
      .clk_i       (clk),
      .rst_ni      (reset),
      .cmd_valid_i (cmd_valid),
      .cmd_op_i    (cmd_op),
      .cmd_len_i   (cmd_len),
      .cmd_acc_i   (cmd_acc),
      .mode_i      (mode_eff),
      .l0_empty_i  (l0_empty),
      .if_empty_i  (if_empty),
      .of_valid_i  (of_valid),
      .out_ready_i (out_ready),
      .wr_err_i    (wr_err),
      .cmd_ready_o (cmd_ready),
      .done_o      (done),
      .err_o       (err),
      .out_valid_o (out_valid),
      .acc_o       (acc_q),
      .mode_o      (mode_q),
      .state_o     (state),
      .inst_w_o    (inst_w),
      .l0_rd_o     (l0_rd),
      .if_rd_o     (if_rd),
      .of_pop_o    (of_pop)
   );

endmodule

// File: tb/tb_corelet_seq.sv
// tb_corelet_seq: directed checks of corelet_seq command flow, stalls, drain and reset abort.
module tb_corelet_seq;
   import corelet_pkg::*;

   logic         clk = 1'b0, reset = 1'b0, mode = 1'b0;
   logic         act_wr = 1'b0, w_wr = 1'b0, cmd_valid = 1'b0, cmd_acc = 1'b0, out_ready = 1'b0;
   logic [31:0]  act_in = '0, w_in = '0;
   logic [1:0]   cmd_op = '0;
   logic [7:0]   cmd_len = '0;
   logic [127:0] sfp_in = '0;
   logic [127:0] out_data;
   logic         cmd_ready, out_valid, busy, done, err, in_full;

   int n_chk = 0, n_bad = 0;
   int n_rd = 0, n_ld = 0, n_ex = 0, n_stall = 0, n_flush = 0, n_done = 0, n_err = 0, n_pop = 0;
   int b_rd, b_ld, b_ex, b_stall, b_flush, b_done, b_err, b_pop;
   logic [127:0] cap_in_n = {8{16'h5A5A}};
   logic [15:0]  dexp [4] = '{16'd156, 16'd212, 16'd268, 16'd44};
   logic         exp_werr;
   logic [15:0]  exp_in_n;

   corelet_seq dut (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode),
      .act_in    (act_in),
      .act_wr    (act_wr),
      .w_in      (w_in),
      .w_wr      (w_wr),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_len   (cmd_len),
      .cmd_acc   (cmd_acc),
      .sfp_in    (sfp_in),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .in_full   (in_full)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (dut.l0_rd) n_rd = n_rd + 1;
      if (dut.inst_w == 2'b01) n_ld = n_ld + 1;
      if (dut.inst_w == 2'b10) begin
         n_ex     = n_ex + 1;
         cap_in_n = dut.in_n;
      end
      if ((dut.state == StLoad || dut.state == StExec) && dut.inst_w == 2'b00)
         n_stall = n_stall + 1;
      if (dut.state == StFlush) n_flush = n_flush + 1;
      if (done) n_done = n_done + 1;
      if (err) n_err = n_err + 1;
      if (out_valid && out_ready) n_pop = n_pop + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic snap();
      b_rd = n_rd; b_ld = n_ld; b_ex = n_ex; b_stall = n_stall;
      b_flush = n_flush; b_done = n_done; b_err = n_err; b_pop = n_pop;
   endtask

   task automatic push_act(input logic [3:0] v);
      act_in = {8{v}};
      act_wr = 1'b1;
      tick();
      act_wr = 1'b0;
   endtask

   task automatic issue(input logic [1:0] op, input logic [7:0] len, input logic acc,
                        input logic md);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_len   = len;
      cmd_acc   = acc;
      mode      = md;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy && k < 200) begin
         tick();
         k++;
      end
      check_eq({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      tick();
      tick();
      reset = 1'b1;
      tick();
      check_eq("rst_cmd_ready", cmd_ready, 1'b1);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_err", err, 1'b0);
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_out_data", out_data, '0);
      check_eq("rst_in_full", in_full, 1'b0);

      // Fill L0, then overflow it once; the last kept row (all 7s) becomes the weights.
      for (int k = 0; k < 8; k++) push_act(4'(k));
      check_eq("l0_full", in_full, 1'b1);
      push_act(4'hA);
      check_eq("ovf_err", err, 1'b1);
      tick();
      check_eq("ovf_err_clr", err, 1'b0);

      snap();
      issue(OpLoad, 8'd8, 1'b0, 1'b0);
      check_eq("load_busy", busy, 1'b1);
      check_eq("load_cmd_ready", cmd_ready, 1'b0);
      wait_idle("load");
      check_eq("load_done", done, 1'b1);
      tick();
      check_eq("load_done_once", done, 1'b0);
      check_eq("load_reads", n_rd - b_rd, 8);
      check_eq("load_inst", n_ld - b_ld, 8);
      check_eq("load_flush", n_flush - b_flush, 16);
      check_eq("load_ndone", n_done - b_done, 1);
      check_eq("load_in_full", in_full, 1'b0);

      // EXEC len 4: two rows queued, L0 runs dry for three cycles, two more arrive.
      push_act(4'd1);
      push_act(4'd2);
      snap();
      issue(OpExec, 8'd4, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) tick();
      act_in = {8{4'd3}};
      act_wr = 1'b1;
      tick();
      act_in = {8{4'hF}};
      tick();
      act_wr = 1'b0;
      wait_idle("exec");
      check_eq("exec_done", done, 1'b1);
      tick();
      check_eq("exec_reads", n_rd - b_rd, 4);
      check_eq("exec_inst", n_ex - b_ex, 4);
      check_eq("exec_stall", n_stall - b_stall, 3);
      check_eq("exec_flush", n_flush - b_flush, 16);
      check_eq("exec_ndone", n_done - b_done, 1);

      // DRAIN len 4 with SFP accumulate of 100; results 56,112,168,-56 plus 100.
      sfp_in = {8{16'd100}};
      snap();
      issue(OpDrain, 8'd4, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         out_ready = (i % 2 == 0);
         check_eq($sformatf("drain_valid%0d", i), out_valid, 1'b1);
         check_eq($sformatf("drain_data%0d", i), out_data, {8{dexp[(i + 1) / 2]}});
         tick();
      end
      out_ready = 1'b0;
      check_eq("drain_done", done, 1'b1);
      check_eq("drain_busy", busy, 1'b0);
      check_eq("drain_out_valid", out_valid, 1'b0);
      tick();
      check_eq("drain_pops", n_pop - b_pop, 4);
      check_eq("drain_ndone", n_done - b_done, 1);

      // Illegal opcode, then zero-length command, with one row waiting in L0.
      push_act(4'd5);
      snap();
      issue(OpBad, 8'd5, 1'b0, 1'b0);
      check_eq("bad_err", err, 1'b1);
      check_eq("bad_idle", cmd_ready, 1'b1);
      tick();
      check_eq("bad_err_clr", err, 1'b0);
      issue(OpExec, 8'd0, 1'b0, 1'b0);
      check_eq("len0_done", done, 1'b1);
      check_eq("len0_busy", busy, 1'b0);
      tick();
      check_eq("len0_done_clr", done, 1'b0);
      check_eq("len0_reads", n_rd - b_rd, 0);
      check_eq("len0_nerr", n_err - b_err, 1);
      check_eq("len0_ndone", n_done - b_done, 1);

      // Reset mid-EXEC aborts without done.
      snap();
      issue(OpExec, 8'd4, 1'b0, 1'b0);
      tick();
      check_eq("abort_busy_pre", busy, 1'b1);
      #2 reset = 1'b0;
      #1;
      check_eq("abort_busy", busy, 1'b0);
      check_eq("abort_cmd_ready", cmd_ready, 1'b1);
      check_eq("abort_state", dut.state == StIdle, 1'b1);
      tick();
      reset = 1'b1;
      tick();
      tick();
      check_eq("abort_ndone", n_done - b_done, 0);
      check_eq("abort_done", done, 1'b0);
      check_eq("abort_out_valid", out_valid, 1'b0);

      // Output-stationary weight 4'hF sign-extends into in_n; weights are zero after reset.
`ifdef CORELET_SEQ_OS_EN
      exp_werr = 1'b0;
      exp_in_n = 16'hFFFF;
`else
      exp_werr = 1'b1;
      exp_in_n = 16'h0000;
`endif
      w_in = {8{4'hF}};
      w_wr = 1'b1;
      tick();
      w_wr = 1'b0;
      check_eq("w_wr_err", err, exp_werr);
      push_act(4'd2);
      snap();
      issue(OpExec, 8'd1, 1'b0, 1'b1);
      wait_idle("os_exec");
      tick();
      check_eq("os_exec_inst", n_ex - b_ex, 1);
      check_eq("os_in_n_lane0", cap_in_n[15:0], exp_in_n);
      issue(OpDrain, 8'd1, 1'b0, 1'b0);
      check_eq("os_out_valid", out_valid, 1'b1);
      check_eq("os_out_data", out_data, {8{exp_in_n}});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("os_drain_done", done, 1'b1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/corelet_seq.md
CORELET_SEQ -- requirements
Module: corelet_seq

Interface
REQ-001 Parameter bw, default 4, activation/weight element width.
REQ-002 Parameter psum_bw, default 16, partial-sum width.
REQ-003 Parameter row, default 8, array rows and L0/IFIFO lanes.
REQ-004 Parameter col, default 8, array columns and OFIFO lanes.
REQ-005 Parameter LEN_W, default 8, command length counter width.
REQ-006 Port clk  in  1  sole clock, rising edge.
REQ-007 Port reset  in  1  asynchronous, active-low reset.
REQ-008 Port mode  in  1  0 = weight-stationary, 1 = output-stationary; sampled on command accept.
REQ-009 Ports act_in  in  bw*row, act_wr  in  1  L0 activation write.
REQ-010 Ports w_in  in  bw*row, w_wr  in  1  IFIFO weight write.
REQ-011 Ports cmd_valid  in  1, cmd_ready  out  1, cmd_op  in  2, cmd_len  in  LEN_W, cmd_acc  in  1  command handshake.
REQ-012 Port sfp_in  in  psum_bw*col  accumulation operand to SFP.
REQ-013 Ports out_data  out  psum_bw*col, out_valid  out  1, out_ready  in  1  result stream.
REQ-014 Ports busy  out  1, done  out  1, err  out  1, in_full  out  1 (L0 or IFIFO full).

Function
REQ-015 FSM states IDLE, LOAD, EXEC, FLUSH, DRAIN; cmd_ready SHALL be 1 only in IDLE; busy = state != IDLE.
REQ-016 Command accepted on cmd_valid && cmd_ready; op, len, acc, mode SHALL be registered at accept.
REQ-017 cmd_op 0 -> LOAD (inst_w=01), 1 -> EXEC (inst_w=10), 2 -> DRAIN; 3 SHALL pulse err one cycle and remain IDLE.
REQ-018 cmd_len 0 SHALL return to IDLE next cycle with a one-cycle done pulse and no FIFO reads.
REQ-019 LOAD/EXEC: one L0 read per cycle while L0 non-empty; read count SHALL increment only on issued reads; empty L0 stalls with inst_w=00.
REQ-020 In EXEC with registered mode 1, L0 and IFIFO SHALL be read together, only when both non-empty; IFIFO data sign-extended to psum_bw per column into in_n.
REQ-021 In mode 0 in_n SHALL be zero and IFIFO SHALL not be read.
REQ-022 When read count reaches cmd_len, FSM SHALL enter FLUSH for exactly row+col cycles with inst_w=00, then IDLE with done pulse.
REQ-023 DRAIN: out_valid = OFIFO valid; OFIFO pop SHALL occur only on out_valid && out_ready; after cmd_len pops, IDLE with done pulse.
REQ-024 out_data SHALL be SFP output when acc=1 and mode=0, else OFIFO output; out_data SHALL hold stable while out_valid && !out_ready.
REQ-025 act_wr/w_wr to a full FIFO SHALL be dropped and pulse err; writes SHALL be accepted in every state.
REQ-026 Simultaneous FIFO write and read in the same cycle SHALL both take effect.

Reset
REQ-027 reset low SHALL asynchronously force IDLE, zero counters, flush FIFOs and array, and drive cmd_ready=1, busy=0, done=0, err=0, out_valid=0, out_data=0.
REQ-028 Reset asserted mid-command SHALL abort it with no done pulse.

Configuration
REQ-029 Macro CORELET_SEQ_OS_EN defined: output-stationary path (REQ-020) compiled in.
REQ-030 Macro undefined: mode port ignored and treated as 0, IFIFO and sign-extension removed, w_wr always pulses err.

Structure
REQ-031 Package corelet_pkg SHALL hold state enum, cmd_op encodings, inst_w encodings.
REQ-032 Sub-module corelet_seq_ctrl SHALL hold FSM, counters and handshakes; top instantiates it with l0_fifo, ofifo, mac_array, sfp.

Verification
REQ-033 Write 8 weight rows, cmd LOAD len 8 -> 8 L0 reads, 16 FLUSH cycles, done pulse, busy low.
REQ-034 cmd EXEC len 4 with L0 empty for 3 cycles mid-stream -> exactly 4 reads, stall inst_w=00, done once.
REQ-035 cmd DRAIN len 4, out_ready toggling 1010 -> 4 pops, out_data stable during stalls.
REQ-036 cmd_op 3, then cmd_len 0 -> err pulse then done pulse, no FIFO activity.
REQ-037 reset low during EXEC cycle 2 -> IDLE immediately, cmd_ready=1, no done.
REQ-038 OS_EN defined, mode 1, weight 4'hF -> in_n lane = 16'hFFFF; undefined -> in_n = 0.
